// File: rtl/key_pkg.sv
// Shared types and constants for the key bounce emulator: FSM states and the
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used for random segment lengths.
package key_pkg;

   localparam int LFSR_W = 16;

   // Bit positions 15,13,12,10 correspond to taps 16,14,13,11.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BOUNCE = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/key_lfsr.sv
// 16-bit Fibonacci LFSR, steps once per cycle with advance high; 1-cycle latency.
// No backpressure: the caller decides when to advance; rnd exposes the low OUT_W bits.
module key_lfsr
   import key_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
   parameter int                OUT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   output logic [OUT_W-1:0] rnd
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (advance) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/key_bounce_gen.sv
// Mechanical-key emulator: on command, key_out bounces 2*BOUNCES+1 edges then holds N cycles; done pulses at the end.
// First edge is registered at the accept edge; cmd_ready only in IDLE, requests while busy are ignored. KEY_BOUNCE_RANDOM_EN selects LFSR segment lengths.
module key_bounce_gen
   import key_pkg::*;
#(
   parameter int                N          = 10,
   parameter int                BOUNCES    = 2,
   parameter int                GLITCH_W   = 2,
   parameter logic              IDLE_LEVEL = 1'b0,
   parameter logic [LFSR_W-1:0] SEED       = 16'hACE1
) (
   input  logic clk,
   input  logic reset,
   input  logic cmd_valid,
   input  logic cmd_level,
   output logic cmd_ready,
   output logic key_out,
   output logic busy,
   output logic done
);

   localparam int SEG_W  = GLITCH_W + 1;
   localparam int HOLD_W = $clog2(N + 1);
   localparam int TOG_W  = $clog2(2 * BOUNCES + 2);

   localparam logic [SEG_W-1:0]  SEG_MAX  = {1'b1, {GLITCH_W{1'b0}}};
   localparam logic [HOLD_W-1:0] HOLD_N   = HOLD_W'(N);
   localparam logic [TOG_W-1:0]  TOG_LAST = TOG_W'(2 * BOUNCES - 1);

   if (SEED == '0) begin : g_seed_chk
      $error("key_bounce_gen: SEED must be nonzero");
   end

   state_t             state_q, state_d;
   logic               key_q, key_d;
   logic               target_q, target_d;
   logic [SEG_W-1:0]   seg_q, seg_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [TOG_W-1:0]   tog_q, tog_d;
   logic               done_q, done_d;
   logic               seg_load;
   logic [SEG_W-1:0]   seg_len;
   logic               seg_expire;
   logic               hold_expire;
   logic               accept;

`ifdef KEY_BOUNCE_RANDOM_EN
   logic [GLITCH_W-1:0] rnd;

   key_lfsr #(
      .SEED  (SEED),
      .OUT_W (GLITCH_W)
   ) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .advance (seg_load),
      .rnd     (rnd)
   );

   assign seg_len = SEG_W'(rnd) + SEG_W'(1);
`else
   assign seg_len = SEG_MAX;
`endif

   assign accept      = cmd_valid && (state_q == ST_IDLE);
   assign seg_expire  = (seg_q == SEG_W'(1));
   assign hold_expire = (hold_q == HOLD_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         key_q    <= IDLE_LEVEL;
         target_q <= IDLE_LEVEL;
         seg_q    <= '0;
         hold_q   <= '0;
         tog_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         key_q    <= key_d;
         target_q <= target_d;
         seg_q    <= seg_d;
         hold_q   <= hold_d;
         tog_q    <= tog_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if ((cmd_level != key_q) && (BOUNCES > 0)) begin
                  state_d = ST_BOUNCE;
               end else begin
                  state_d = ST_SETTLE;
               end
            end
         end
         ST_BOUNCE: begin
            if (seg_expire && (tog_q == TOG_LAST)) begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (hold_expire) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      key_d    = key_q;
      target_d = target_q;
      seg_d    = seg_q;
      hold_d   = hold_q;
      tog_d    = tog_q;
      done_d   = 1'b0;
      seg_load = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               target_d = cmd_level;
               hold_d   = HOLD_N;
               if (cmd_level != key_q) begin
                  key_d    = cmd_level;
                  tog_d    = '0;
                  seg_load = (BOUNCES > 0);
               end
            end
         end
         ST_BOUNCE: begin
            if (seg_expire) begin
               // The last toggle lands on target by construction; force it so the end level never drifts.
               if (tog_q == TOG_LAST) begin
                  key_d  = target_q;
                  hold_d = HOLD_N;
               end else begin
                  key_d    = ~key_q;
                  tog_d    = tog_q + TOG_W'(1);
                  seg_load = 1'b1;
               end
            end else begin
               seg_d = seg_q - SEG_W'(1);
            end
         end
         ST_SETTLE: begin
            if (hold_expire) begin
               done_d = 1'b1;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         default: begin
            done_d = 1'b0;
         end
      endcase
      if (seg_load) begin
         seg_d = seg_len;
      end
   end

   always_comb begin
      cmd_ready = (state_q == ST_IDLE);
      busy      = (state_q != ST_IDLE);
      key_out   = key_q;
      done      = done_q;
   end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed bench for key_bounce_gen in fixed-segment mode (BOUNCES=2, GLITCH_W=2, N=10).
module tb_key_bounce_gen;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cmd_valid = 1'b0;
   logic cmd_level = 1'b0;
   logic cmd_ready;
   logic key_out;
   logic busy;
   logic done;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   key_bounce_gen #(
      .N          (10),
      .BOUNCES    (2),
      .GLITCH_W   (2),
      .IDLE_LEVEL (1'b0),
      .SEED       (16'hACE1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_level (cmd_level),
      .cmd_ready (cmd_ready),
      .key_out   (key_out),
      .busy      (busy),
      .done      (done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller sets cmd_valid/cmd_level first; the first step here is the accept edge t0.
   // Segments are 4 cycles: toggles at t0,+4,+8,+12,+16; done at +26, or +10 with no change.
   task automatic run_cmd(input logic tgt, input logic start, input bit drop, input logic next_lvl);
      bit   changed;
      int   d;
      int   toggles;
      logic prev;
      logic exp_key;
      changed = (tgt != start);
      d       = changed ? 26 : 10;
      toggles = 0;
      prev    = start;
      for (int k = 0; k <= d; k++) begin
         step();
         if (k == 0) begin
            if (drop) cmd_valid = 1'b0;
            else      cmd_level = next_lvl;
         end
         if (!changed || k >= 16) exp_key = tgt;
         else if (((k / 4) % 2) == 0) exp_key = tgt;
         else exp_key = ~tgt;
         if (key_out !== prev) toggles++;
         prev = key_out;
         chk($sformatf("key_k%0d", k), 32'(key_out), 32'(exp_key));
         chk($sformatf("done_k%0d", k), 32'(done), 32'(k == d));
         chk($sformatf("ready_k%0d", k), 32'(cmd_ready), 32'(k == d));
         chk($sformatf("busy_k%0d", k), 32'(busy), 32'(k < d));
      end
      chk("toggle_count", 32'(toggles), changed ? 32'd5 : 32'd0);
   endtask

   initial begin
      int dones;
      int key_highs;

      // Reset held for three edges
      reset = 1'b1;
      step();
      step();
      step();
      chk("rst_key", 32'(key_out), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      step();
      chk("idle_ready", 32'(cmd_ready), 32'd1);

      // No-change command: level already 0
      cmd_level = 1'b0;
      cmd_valid = 1'b1;
      run_cmd(1'b0, 1'b0, 1'b1, 1'b0);

      // Press to 1 with full bounce pattern
      step();
      cmd_level = 1'b1;
      cmd_valid = 1'b1;
      run_cmd(1'b1, 1'b0, 1'b1, 1'b0);

      // Release with cmd_valid held throughout, then a press accepted right after done
      step();
      cmd_level = 1'b0;
      cmd_valid = 1'b1;
      run_cmd(1'b0, 1'b1, 1'b0, 1'b1);
      run_cmd(1'b1, 1'b0, 1'b1, 1'b0);

      // Reset during BOUNCE: release command, reset lands on edge t0+6
      step();
      cmd_level = 1'b0;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("mid_k0_key", 32'(key_out), 32'd0);
      chk("mid_k0_busy", 32'(busy), 32'd1);
      for (int k = 1; k <= 5; k++) step();
      chk("mid_k5_key", 32'(key_out), 32'd1);
      reset = 1'b1;
      step();
      chk("mid_rst_key", 32'(key_out), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      dones = 0;
      key_highs = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (done === 1'b1) dones++;
         if (key_out !== 1'b0) key_highs++;
      end
      chk("post_rst_no_done", 32'(dones), 32'd0);
      chk("post_rst_key_quiet", 32'(key_highs), 32'd0);
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
